// File: rtl/mux.sv
// Two-input data selector with a combinational output and an enabled, registered
// copy of the result, the select, and a select-transition pulse.
module mux #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             select,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_changed
);

  // Case-equality keeps an unknown select from silently merging in1/in2 bits.
  assign out = (select === 1'b1) ? in2 :
               (select === 1'b0) ? in1 : {WIDTH{1'bx}};

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= RESET_VALUE;
      sel_q       <= 1'b0;
      sel_changed <= 1'b0;
    end else if (en) begin
      out_q       <= out;
      sel_q       <= select;
      sel_changed <= (select != sel_q);
    end else begin
      sel_changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Directed plus randomized checks of mux against a behavioural model of its
// selection, capture and select-transition rules.
module tb_mux;
  logic        clk = 1'b0;
  logic        reset, select, en;
  logic [31:0] in1, in2, out, out_q;
  logic        sel_q, sel_changed;

  logic        a1, b1, o1, oq1, sq1, sc1;
  logic [63:0] a64, b64, o64, oq64;
  logic        sq64, sc64;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_outq;
  logic        m_selq, m_chg;

  always #5 clk = ~clk;

  mux dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .select(select), .en(en),
    .out(out), .out_q(out_q), .sel_q(sel_q), .sel_changed(sel_changed)
  );

  mux #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .in1(a1), .in2(b1), .select(select), .en(en),
    .out(o1), .out_q(oq1), .sel_q(sq1), .sel_changed(sc1)
  );

  mux #(.WIDTH(64)) dut_w64 (
    .clk(clk), .reset(reset), .in1(a64), .in2(b64), .select(select), .en(en),
    .out(o64), .out_q(oq64), .sel_q(sq64), .sel_changed(sc64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model the edge from the values applied just before it, then compare after it.
  task automatic tick();
    logic [31:0] sel_val;
    sel_val = select ? in2 : in1;
    if (reset) begin
      m_outq = 32'h0; m_selq = 1'b0; m_chg = 1'b0;
    end else if (en) begin
      m_chg  = (select != m_selq);
      m_outq = sel_val;
      m_selq = select;
    end else begin
      m_chg = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".out_q"}, 64'(out_q), 64'(m_outq));
    chk({tag, ".sel_q"}, 64'(sel_q), 64'(m_selq));
    chk({tag, ".sel_changed"}, 64'(sel_changed), 64'(m_chg));
  endtask

  initial begin
    int pulses;
    reset = 1'b1; en = 1'b0; select = 1'b0; in1 = '0; in2 = '0;
    a1 = 1'b0; b1 = 1'b0; a64 = '0; b64 = '0;
    m_outq = 32'hFFFF_FFFF; m_selq = 1'b1; m_chg = 1'b1;
    tick();
    chk_regs("reset");
    chk("reset.out_q_zero", 64'(out_q), 64'h0);

    // combinational selection, no edge involved
    reset = 1'b0;
    in1 = 32'hABCDEF00; in2 = 32'h00FEDCBA; select = 1'b0; #1;
    chk("comb.sel0", 64'(out), 64'hABCDEF00);
    select = 1'b1; #1;
    chk("comb.sel1", 64'(out), 64'h00FEDCBA);

    // reset with en=1 still clears; out stays combinational
    en = 1'b1; reset = 1'b1;
    tick();
    chk_regs("reset_en");
    chk("reset_en.out", 64'(out), 64'h00FEDCBA);
    reset = 1'b0;

    // 0 -> 1 toggle, one-cycle latency, single pulse
    select = 1'b0;
    tick();
    chk_regs("tog0");
    chk("tog0.out_q", 64'(out_q), 64'hABCDEF00);
    chk("tog0.nochg", 64'(sel_changed), 64'h0);
    select = 1'b1; #1;
    chk("tog1.pre_out_q", 64'(out_q), 64'hABCDEF00);
    pulses = 0;
    tick();
    chk_regs("tog1");
    chk("tog1.out_q", 64'(out_q), 64'h00FEDCBA);
    pulses += int'(sel_changed);
    tick();
    chk_regs("tog1b");
    pulses += int'(sel_changed);
    chk("tog.pulse_count", 64'(pulses), 64'd1);

    // en=0 hold while inputs change
    en = 1'b0; select = 1'b0; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0;
    tick();
    chk_regs("hold");
    chk("hold.out_q", 64'(out_q), 64'h00FEDCBA);
    chk("hold.out_tracks", 64'(out), 64'h1234_5678);
    chk("hold.sel_q", 64'(sel_q), 64'h1);

    // after reset, first capture with select=0 gives no pulse
    reset = 1'b1; tick(); reset = 1'b0; en = 1'b1; select = 1'b0;
    tick();
    chk("post_reset.sel0_nochg", 64'(sel_changed), 64'h0);
    chk_regs("post_reset0");

    // randomized
    for (int i = 0; i < 300; i++) begin
      in1    = $urandom;
      in2    = $urandom;
      select = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 15) == 0);
      #1;
      chk("rand.out", 64'(out), 64'(select ? in2 : in1));
      tick();
      chk_regs("rand");
    end
    reset = 1'b0;

    // narrow and wide builds with all-ones / all-zeros patterns
    for (int p = 0; p < 2; p++) begin
      a1  = (p == 0);  b1  = (p != 0);
      a64 = (p == 0) ? '1 : '0;  b64 = (p != 0) ? '1 : '0;
      select = 1'b0; #1;
      chk("w1.sel0", 64'(o1), 64'(p == 0));
      chk("w64.sel0", o64, (p == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
      select = 1'b1; #1;
      chk("w1.sel1", 64'(o1), 64'(p != 0));
      chk("w64.sel1", o64, (p != 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0);
    end
    en = 1'b1; select = 1'b1; a64 = 64'h0123_4567_89AB_CDEF; b64 = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    chk("w64.out_q", oq64, 64'hFEDC_BA98_7654_3210);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
